fir_stream: RTL and testbench
=============================

// Module: fir_stream
// PURPOSE
//  Parametrised N-tap direct-form FIR, Q1.(DW-1) fixed point, for the streaming datapath.
//  Adds over the fixed 4-tap filter: valid/ready backpressure, a double-buffered coefficient
//  bank with atomic commit, round-half-up and saturating output, delay-line flush.
//  Sits between the sample source and the downstream consumer; coefficients come from the control block.
// PARAMETERS
//  DW        16  sample/coef width, Q1.(DW-1)
//  NUM_TAPS   8  number of taps, >=2
//  AW        $clog2(NUM_TAPS)  coef address width (derived)
//  ACC_W     2*DW+$clog2(NUM_TAPS)  accumulator width (derived)
// PORTS
//  clk            in   1         clock
//  rst            in   1         synchronous reset, active-high
//  s_valid        in   1         input sample valid
//  s_ready        out  1         block can accept a sample
//  s_data         in   DW        input sample, signed
//  m_valid        out  1         output sample valid
//  m_ready        in   1         downstream accepts output
//  m_data         out  DW        filtered sample, signed
//  m_sat          out  1         m_data was clipped (aligned with m_data)
//  coef_wr_en     in   1         write shadow coefficient
//  coef_addr      in   AW        tap index (0 = newest sample)
//  coef_wr_data   in   DW        coefficient, signed
//  coef_commit    in   1         copy shadow bank -> active bank
//  flush          in   1         clear delay line and in-flight samples
// BEHAVIOUR
//  Reset: m_valid=0, m_data=0, m_sat=0, delay line, pipeline, shadow and active coefs = 0; s_ready=1 next cycle.
//  Stall: adv = !(m_valid && !m_ready); s_ready = adv (combinational). All stages advance only when adv.
//  Accept when s_valid && s_ready: delay line shifts, x[0]<=s_data, x[k]<=x[k-1].
//  Pipeline, each stage carries its own valid bit:
//   S1 delay-line update; S2 p[k] <= x[k]*c_act[k] (2*DW signed);
//   S3 acc <= sign-extended sum of p[0..N-1] (ACC_W, cannot overflow);
//   S4 r = (acc + 2^(DW-2)) >>> (DW-1); clip to [-2^(DW-1), 2^(DW-1)-1]; m_data<=clipped, m_sat<=clipped!=r.
//  Latency: 3 cycles accept->m_valid with m_ready=1; throughput 1 sample/cycle.
//  Output held stable while m_valid && !m_ready; no sample dropped or duplicated.
//  Bubble cycles (no accept) propagate as valid=0 and do not shift the delay line.
//  Coefs: coef_wr_en writes shadow[coef_addr]; out-of-range addr (>=NUM_TAPS) ignored.
//   coef_commit: active <= shadow on that edge; if coef_wr_en same cycle, written value is included.
//   Active bank change affects samples reaching S2 after the commit edge; never mid-product.
//   Commit during stall still takes effect at that edge.
//  flush: delay line, S2-S4 valids cleared next edge; m_valid drops even if m_ready=0;
//   coefs unchanged; s_valid ignored in flush cycle. flush and rst same cycle: rst wins.
//  Reset mid-stream: all in-flight samples discarded, no m_valid until 3 cycles after new accept.
// TESTING (DW=16)
//  1 NUM_TAPS=4, coefs all 0x2000, s_data=0x4000 continuous -> m_data ramps 0x1000,0x2000,0x3000,
//    then 0x4000 steady; first m_valid 3 cycles after first accept; m_sat=0.
//  2 Rounding: tap0=0x0001 others 0: s_data=0x4000 -> 0x0001; s_data=0x3FFF -> 0x0000;
//    s_data=0xC000 -> 0x0000 (half rounds up).
//  3 Saturation: NUM_TAPS=8, coefs 0x7FFF, s_data=0x7FFF x8 -> 0x7FFF, m_sat=1;
//    s_data=0x8000 x8 -> 0x8000, m_sat=1.
//  4 Backpressure: ramp 1..20 (tap0=0x7FFF), m_ready low 5 cycles mid-stream -> s_ready low
//    same cycles, m_data held, output sequence complete and in order.
//  5 Commit mid-stream: shadow tap0 0x2000->0x4000 with writes interleaved -> outputs switch
//    exactly for samples reaching S2 after commit edge; write+commit same cycle uses new value.
//  6 flush and rst asserted with 3 samples in flight -> m_valid=0 next cycle, later outputs
//    see zero history; after rst, coefs read 0 and m_data=0.

Source files
------------

// File: rtl/fir_stream.sv
// Streaming N-tap direct-form FIR (Q1.(DW-1)) with valid/ready backpressure,
// double-buffered coefficients, round-half-up + saturating output and delay-line flush.

module fir_stream_tap #(
    parameter int DW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [DW-1:0]   x_i,
    input  logic [DW-1:0]   c_i,
    output logic [2*DW-1:0] p_o
);
    logic [2*DW-1:0] xs, cs, p_q;

    // Low 2*DW bits of the sign-extended product equal the signed product.
    assign xs = {{DW{x_i[DW-1]}}, x_i};
    assign cs = {{DW{c_i[DW-1]}}, c_i};

    always_ff @(posedge clk_i) begin
        if (rst_i)     p_q <= '0;
        else if (en_i) p_q <= xs * cs;
    end

    assign p_o = p_q;
endmodule

module fir_stream #(
    parameter  int DW       = 16,
    parameter  int NUM_TAPS = 8,
    localparam int AW       = $clog2(NUM_TAPS),
    localparam int ACC_W    = 2*DW + $clog2(NUM_TAPS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [DW-1:0] s_data_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [DW-1:0] m_data_o,
    output logic          m_sat_o,
    input  logic          coef_wr_en_i,
    input  logic [AW-1:0] coef_addr_i,
    input  logic [DW-1:0] coef_wr_data_i,
    input  logic          coef_commit_i,
    input  logic          flush_i
);
    localparam logic [AW:0]                NTAPS_A = (AW+1)'(NUM_TAPS);
    localparam logic [ACC_W-1:0]           HALF    = ACC_W'(1) << (DW-2);
    localparam logic signed [ACC_W-1:0]    MAXV    = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]    MINV    = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [NUM_TAPS-1:0][DW-1:0]   x_q, shd_q, shd_d, act_q;
    logic [NUM_TAPS-1:0][2*DW-1:0] p;
    logic [ACC_W-1:0]              acc_q, sum_d, rnd;
    logic signed [ACC_W-1:0]       r;
    logic [3:0]                    vld_q;
    logic [DW-1:0]                 m_data_q, clip_d;
    logic                          m_sat_q, pos_ovf, neg_ovf;
    logic                          adv, accept;

    assign adv       = !(vld_q[3] && !m_ready_i);
    assign accept    = s_valid_i && adv && !flush_i;
    assign s_ready_o = adv;
    assign m_valid_o = vld_q[3];
    assign m_data_o  = m_data_q;
    assign m_sat_o   = m_sat_q;

    // Shadow bank with the current write merged, so write+commit on one edge commits it.
    always_comb begin
        shd_d = shd_q;
        if (coef_wr_en_i && ({1'b0, coef_addr_i} < NTAPS_A))
            shd_d[coef_addr_i] = coef_wr_data_i;
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        fir_stream_tap #(.DW(DW)) u_tap (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (adv),
            .x_i   (x_q[k]),
            .c_i   (act_q[k]),
            .p_o   (p[k])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NUM_TAPS; k++)
            sum_d = sum_d + {{(ACC_W-2*DW){p[k][2*DW-1]}}, p[k]};
    end

    assign rnd     = acc_q + HALF;
    assign r       = $signed(rnd) >>> (DW-1);
    assign pos_ovf = r > MAXV;
    assign neg_ovf = r < MINV;
    assign clip_d  = pos_ovf ? MAXV[DW-1:0] : (neg_ovf ? MINV[DW-1:0] : r[DW-1:0]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q      <= '0;
            shd_q    <= '0;
            act_q    <= '0;
            acc_q    <= '0;
            vld_q    <= '0;
            m_data_q <= '0;
            m_sat_q  <= 1'b0;
        end else begin
            shd_q <= shd_d;
            // Commit is independent of the stall: products launched later see the new bank.
            if (coef_commit_i) act_q <= shd_d;
            if (flush_i) begin
                x_q   <= '0;
                vld_q <= '0;
            end else if (adv) begin
                if (accept) x_q <= {x_q[NUM_TAPS-2:0], s_data_i};
                vld_q <= {vld_q[2:0], accept};
                acc_q <= sum_d;
                if (vld_q[2]) begin
                    m_data_q <= clip_d;
                    m_sat_q  <= pos_ovf || neg_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_stream.sv
// Directed scoreboard bench for fir_stream (DW=16, 8 taps): ramp, rounding, saturation,
// backpressure, coefficient commit, flush and reset.

module tb_fir_stream;
    typedef struct packed {
        logic [15:0] d;
        logic        s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, m_valid, m_ready, m_sat;
    logic        coef_wr_en, coef_commit, flush;
    logic [15:0] s_data, m_data, coef_wr_data;
    logic [2:0]  coef_addr;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;
    logic signed [15:0] hist[8];
    logic signed [15:0] act[8];
    logic signed [15:0] shd[8];
    logic last_acc, last_srdy;

    always #5 clk = ~clk;

    fir_stream #(.DW(16), .NUM_TAPS(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_sat_o(m_sat),
        .coef_wr_en_i(coef_wr_en), .coef_addr_i(coef_addr), .coef_wr_data_i(coef_wr_data),
        .coef_commit_i(coef_commit), .flush_i(flush)
    );

    function automatic exp_t model_out();
        longint a, r;
        exp_t   e;
        a = 0;
        for (int k = 0; k < 8; k++) a += longint'(hist[k]) * longint'(act[k]);
        r = (a + 64'sd16384) >>> 15;
        if (r > 32767)       begin e.d = 16'h7FFF; e.s = 1'b1; end
        else if (r < -32768) begin e.d = 16'h8000; e.s = 1'b1; end
        else                 begin e.d = r[15:0];  e.s = 1'b0; end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshake before the edge, update the reference model at the edge.
    task automatic clk_step();
        logic acc;
        @(negedge clk);
        acc       = s_valid && s_ready && !flush && !rst;
        last_srdy = s_ready;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 8; k++) begin hist[k] = 0; act[k] = 0; shd[k] = 0; end
            q.delete();
        end else begin
            if (coef_wr_en) shd[coef_addr] = coef_wr_data;
            if (coef_commit) for (int k = 0; k < 8; k++) act[k] = shd[k];
            if (flush) begin
                for (int k = 0; k < 8; k++) hist[k] = 0;
                q.delete();
            end else if (acc) begin
                for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = s_data;
                q.push_back(model_out());
            end
        end
        last_acc = acc;
        #1;
        coef_wr_en = 1'b0; coef_commit = 1'b0; flush = 1'b0;
    endtask

    task automatic bubble(input int n);
        s_valid = 1'b0;
        repeat (n) clk_step();
    endtask

    task automatic send(input logic [15:0] d);
        int n;
        s_valid = 1'b1; s_data = d; n = 0;
        do begin clk_step(); n++; end while (!last_acc && n < 50);
        chk("send_accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic load(input logic [15:0] v, input int n);
        s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            coef_wr_en = 1'b1; coef_addr = 3'(k); coef_wr_data = (k < n) ? v : 16'h0000;
            clk_step();
        end
        coef_commit = 1'b1;
        clk_step();
    endtask

    task automatic drain();
        int n;
        s_valid = 1'b0; m_ready = 1'b1; n = 0;
        while ((q.size() != 0 || m_valid) && n < 200) begin clk_step(); n++; end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed output %h, expected none", m_data);
            end
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                checks++;
                assert (m_data === mon_e.d) else begin
                    errors++;
                    $error("FAIL sb_data: observed %h expected %h", m_data, mon_e.d);
                end
                checks++;
                assert (m_sat === mon_e.s) else begin
                    errors++;
                    $error("FAIL sb_sat: observed %b expected %b", m_sat, mon_e.s);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int idx, cyc;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        coef_wr_en = 1'b0; coef_addr = '0; coef_wr_data = '0; coef_commit = 1'b0; flush = 1'b0;
        repeat (2) clk_step();
        rst = 1'b0;
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_mdata", 32'(m_data), 32'd0);
        chk("rst_msat", 32'(m_sat), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd1);

        // Ramp: 4 taps of 0.25, constant 0.5 input, 3-cycle latency.
        load(16'h2000, 4);
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1; s_data = 16'h4000;
            clk_step();
            chk("lat_mvalid", 32'(m_valid), 32'(i >= 3));
            if (i >= 3)
                chk("ramp_data", 32'(m_data), (i == 3) ? 32'h1000 : (i == 4) ? 32'h2000 :
                                              (i == 5) ? 32'h3000 : 32'h4000);
        end
        drain();

        // Rounding on a single LSB coefficient.
        load(16'h0001, 1);
        send(16'h4000); send(16'h3FFF); send(16'hC000);
        drain();

        // Saturation in both directions.
        load(16'h7FFF, 8);
        for (int i = 0; i < 19; i++) begin
            s_valid = 1'b1; s_data = (i < 8) ? 16'h7FFF : 16'h8000;
            clk_step();
            if (i == 10) begin
                chk("sat_pos_data", 32'(m_data), 32'h7FFF);
                chk("sat_pos_flag", 32'(m_sat), 32'd1);
            end
            if (i == 18) begin
                chk("sat_neg_data", 32'(m_data), 32'h8000);
                chk("sat_neg_flag", 32'(m_sat), 32'd1);
            end
        end
        drain();

        // Backpressure: m_ready low for 5 cycles mid-stream.
        load(16'h7FFF, 1);
        idx = 1; cyc = 0;
        while (idx <= 20 && cyc < 200) begin
            m_ready = !(cyc >= 8 && cyc <= 12);
            s_valid = 1'b1; s_data = 16'(idx);
            clk_step();
            chk("bp_sready", 32'(last_srdy), (cyc >= 8 && cyc <= 12) ? 32'd0 : 32'd1);
            if (cyc >= 8 && cyc <= 12 && q.size() > 0) begin
                chk("bp_hold_valid", 32'(m_valid), 32'd1);
                chk("bp_hold_data", 32'(m_data), 32'(q[0].d));
            end
            if (last_acc) idx++;
            cyc++;
        end
        chk("bp_all_sent", 32'(idx), 32'd21);
        drain();

        // Commit mid-stream with interleaved shadow writes.
        load(16'h2000, 1);
        drain();
        for (int i = 0; i < 13; i++) begin
            d = 16'h1000 + 16'(i) * 16'h0100;
            s_valid = 1'b1; s_data = d;
            if (i == 2) begin coef_wr_en = 1'b1; coef_addr = 3'd0; coef_wr_data = 16'h4000; end
            if (i == 4) begin coef_wr_en = 1'b1; coef_addr = 3'd5; coef_wr_data = 16'h0000; end
            if (i == 6) coef_commit = 1'b1;
            if (i == 9) begin
                coef_wr_en = 1'b1; coef_addr = 3'd0; coef_wr_data = 16'h6000; coef_commit = 1'b1;
            end
            clk_step();
            if (i == 8)  chk("commit_old", 32'(m_data), 32'h0540);
            if (i == 9)  chk("commit_new", 32'(m_data), 32'h0B00);
            if (i == 11) chk("commit_hold", 32'(m_data), 32'h0C00);
            if (i == 12) chk("commit_wr_same", 32'(m_data), 32'h12C0);
        end
        drain();

        // Commit while the output is stalled.
        m_ready = 1'b0;
        send(16'h4000);
        bubble(3);
        chk("stall_mvalid", 32'(m_valid), 32'd1);
        coef_wr_en = 1'b1; coef_addr = 3'd0; coef_wr_data = 16'h2000; coef_commit = 1'b1;
        clk_step();
        drain();
        send(16'h4000);
        bubble(3);
        chk("stall_commit_data", 32'(m_data), 32'h1000);
        drain();

        // Flush with 3 samples in flight; s_valid in the flush cycle is ignored.
        load(16'h2000, 2);
        send(16'h4000); send(16'h4000); send(16'h4000);
        s_data = 16'h7000; flush = 1'b1;
        clk_step();
        chk("flush_mvalid", 32'(m_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bubble(1);
            chk("flush_quiet", 32'(m_valid), 32'd0);
        end
        send(16'h4000);
        bubble(3);
        chk("flush_hist_valid", 32'(m_valid), 32'd1);
        chk("flush_hist_data", 32'(m_data), 32'h1000);
        drain();

        // Flush while stalled drops the held output.
        m_ready = 1'b0;
        send(16'h4000); send(16'h2000);
        bubble(2);
        chk("flush_stall_pre", 32'(m_valid), 32'd1);
        flush = 1'b1;
        clk_step();
        chk("flush_stall_mvalid", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bubble(1);
            chk("flush_stall_quiet", 32'(m_valid), 32'd0);
        end
        drain();

        // Reset together with flush, 3 samples in flight.
        send(16'h4000); send(16'h4000); send(16'h4000);
        s_valid = 1'b0; rst = 1'b1; flush = 1'b1;
        clk_step();
        rst = 1'b0;
        chk("rst2_mvalid", 32'(m_valid), 32'd0);
        chk("rst2_mdata", 32'(m_data), 32'd0);
        chk("rst2_msat", 32'(m_sat), 32'd0);
        chk("rst2_sready", 32'(s_ready), 32'd1);
        coef_commit = 1'b1;
        clk_step();
        send(16'h7FFF);
        for (int i = 1; i <= 3; i++) begin
            bubble(1);
            chk("rst2_lat", 32'(m_valid), 32'(i == 3));
        end
        chk("rst2_zero_coef", 32'(m_data), 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
